// File: rtl/clint_dbus_responder.sv
// CLINT responder on the data bus: msip, mtimecmp and mtime with timer/software interrupts.
// Optional feature macro: CLINT_MTIME_WRITE_EN (mtime writable from the bus).

typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
} dbus_req_t;

typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
} dbus_resp_t;

module clint_dbus_responder #(
    parameter logic [63:0] BASE     = 64'h0200_0000,
    parameter int unsigned PRESCALE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       sel,
    output logic       trint,
    output logic       swint
);

    localparam int unsigned   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic {IDLE, RESP} state_t;
    state_t state, state_next;

    logic [63:0]   offset;
    logic [63:0]   rdata;
    logic [63:0]   resp_data;
    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic          msip;
    logic [PW-1:0] prescnt;
    logic          tick;
    logic          accept;
    logic          wr;
    logic          hit_msip;
    logic          hit_cmp;
    logic          hit_mtime;
    logic          mtime_wr;
    logic          unused_bits;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wdata,
                                          input logic [7:0] strb);
        logic [63:0] m;
        m = old;
        for (int unsigned i = 0; i < 8; i++) begin
            if (strb[i]) m[i*8 +: 8] = wdata[i*8 +: 8];
        end
        return m;
    endfunction

    assign offset      = dreq.addr - BASE;
    assign sel         = dreq.valid && (dreq.addr >= BASE) && (offset[63:16] == '0);
    assign hit_msip    = (offset[15:3] == 13'h0000);
    assign hit_cmp     = (offset[15:3] == 13'h0800);
    assign hit_mtime   = (offset[15:3] == 13'h17FF);
    assign accept      = (state == IDLE) && sel;
    assign wr          = accept && (dreq.strobe != '0);
    assign tick        = (prescnt == PMAX);
    assign unused_bits = ^{dreq.size, offset[2:0]};

`ifdef CLINT_MTIME_WRITE_EN
    assign mtime_wr = wr && hit_mtime;
`else
    assign mtime_wr = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        if (hit_msip)       rdata = {63'b0, msip};
        else if (hit_cmp)   rdata = mtimecmp;
        else if (hit_mtime) rdata = mtime;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // A request still held during RESP is not re-served: RESP always returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (sel) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dresp = '0;
        if (state == RESP) begin
            dresp.addr_ok = 1'b1;
            dresp.data_ok = 1'b1;
            dresp.data    = resp_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_data <= '0;
            msip      <= 1'b0;
            mtimecmp  <= '1;
            trint     <= 1'b0;
            swint     <= 1'b0;
        end else begin
            if (accept) resp_data <= rdata;
            if (wr && hit_msip && dreq.strobe[0]) msip <= dreq.data[0];
            if (wr && hit_cmp) mtimecmp <= merge(mtimecmp, dreq.data, dreq.strobe);
            trint <= (mtime >= mtimecmp);
            swint <= msip;
        end
    end

    // A bus write to mtime overrides the tick in the same cycle and restarts the prescaler.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescnt <= '0;
            mtime   <= '0;
        end else if (mtime_wr) begin
            prescnt <= '0;
            mtime   <= merge(mtime, dreq.data, dreq.strobe);
        end else begin
            prescnt <= tick ? '0 : prescnt + 1'b1;
            if (tick) mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: tb/tb_clint_dbus_responder.sv
// Bench for clint_dbus_responder: directed steps plus random register traffic against a
// timeline model (mtime as a function of elapsed clock edges, registers as value histories).

module tb_clint_dbus_responder;

    localparam logic [63:0] BASE    = 64'h0200_0000;
    localparam int unsigned P       = 1;
    localparam logic [63:0] A_MSIP  = BASE;
    localparam logic [63:0] A_CMP   = BASE + 64'h4000;
    localparam logic [63:0] A_MTIME = BASE + 64'hBFF8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic       sel;
    logic       trint;
    logic       swint;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned edges = 0;

    // mtime timeline: value b1 at edge e1 advancing one per P edges; b0/e0 is the prior segment.
    logic [63:0] mt_b0, mt_b1;
    int unsigned mt_e0, mt_e1;
    logic [63:0] cmp_old, cmp_new;
    int unsigned cmp_edge;
    logic        msip_old, msip_new;
    int unsigned msip_edge;

    clint_dbus_responder #(.BASE(BASE), .PRESCALE(P)) dut (
        .clk(clk), .reset(reset), .dreq(dreq), .dresp(dresp),
        .sel(sel), .trint(trint), .swint(swint)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] mtime_at(input int unsigned k);
        if (k >= mt_e1) return mt_b1 + 64'((k - mt_e1) / P);
        return mt_b0 + 64'((k - mt_e0) / P);
    endfunction

    function automatic logic [63:0] cmp_at(input int unsigned k);
        return (k >= cmp_edge) ? cmp_new : cmp_old;
    endfunction

    function automatic logic msip_at(input int unsigned k);
        return (k >= msip_edge) ? msip_new : msip_old;
    endfunction

    function automatic logic [63:0] bytemerge(input logic [63:0] old, input logic [63:0] wd,
                                              input logic [7:0] strb);
        logic [63:0] m;
        m = old;
        for (int b = 0; b < 8; b++) if (strb[b]) m[b*8 +: 8] = wd[b*8 +: 8];
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_irq(input string tag);
        int unsigned k;
        k = edges;
        if (k == 0) begin
            chk({tag, ".trint"}, 64'(trint), 64'd0);
            chk({tag, ".swint"}, 64'(swint), 64'd0);
        end else begin
            chk({tag, ".trint"}, 64'(trint), 64'(mtime_at(k - 1) >= cmp_at(k - 1)));
            chk({tag, ".swint"}, 64'(swint), 64'(msip_at(k - 1)));
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            chk_irq("idle");
        end
    endtask

    // Called at a negedge with the DUT idle; one request, one response cycle, one idle cycle.
    task automatic xact(input string tag, input logic [63:0] addr, input logic [7:0] strb,
                        input logic [63:0] wd, output logic [63:0] got);
        logic [63:0] off, exp;
        int unsigned k;
        dreq.valid  = 1'b1;
        dreq.addr   = addr;
        dreq.size   = 3'd3;
        dreq.strobe = strb;
        dreq.data   = wd;
        #1;
        chk({tag, ".sel"}, 64'(sel), 64'd1);
        chk({tag, ".early_ok"}, 64'(dresp.data_ok), 64'd0);
        @(negedge clk);
        k   = edges;
        off = addr - BASE;
        case (off[15:3])
            13'h0000: exp = 64'(msip_at(k - 1));
            13'h0800: exp = cmp_at(k - 1);
            13'h17FF: exp = mtime_at(k - 1);
            default:  exp = '0;
        endcase
        got = dresp.data;
        chk({tag, ".addr_ok"}, 64'(dresp.addr_ok), 64'd1);
        chk({tag, ".data_ok"}, 64'(dresp.data_ok), 64'd1);
        chk({tag, ".data"}, dresp.data, exp);
        if (strb != 8'h00) begin
            case (off[15:3])
                13'h0000: if (strb[0]) begin
                    msip_old = msip_at(k - 1); msip_new = wd[0]; msip_edge = k;
                end
                13'h0800: begin
                    cmp_old = cmp_at(k - 1); cmp_new = bytemerge(cmp_old, wd, strb); cmp_edge = k;
                end
`ifdef CLINT_MTIME_WRITE_EN
                13'h17FF: begin
                    logic [63:0] nv;
                    nv = bytemerge(mtime_at(k - 1), wd, strb);
                    mt_b0 = mt_b1; mt_e0 = mt_e1; mt_b1 = nv; mt_e1 = k;
                end
`endif
                default: ;
            endcase
        end
        chk_irq({tag, ".resp"});
        dreq.valid = 1'b0;
        @(negedge clk);
        chk({tag, ".after_ok"}, 64'(dresp.data_ok), 64'd0);
        chk({tag, ".after_aok"}, 64'(dresp.addr_ok), 64'd0);
        chk({tag, ".after_data"}, dresp.data, 64'd0);
        chk_irq({tag, ".after"});
    endtask

    task automatic miss(input string tag, input logic [63:0] addr);
        dreq.valid  = 1'b1;
        dreq.addr   = addr;
        dreq.strobe = 8'h00;
        #1;
        chk({tag, ".sel"}, 64'(sel), 64'd0);
        @(negedge clk);
        chk({tag, ".no_resp"}, 64'(dresp.data_ok), 64'd0);
        dreq.valid = 1'b0;
    endtask

    initial begin
        logic [63:0] got, wd, addr;
        logic [7:0]  strb;
        int unsigned kind;

        dreq  = '0;
        mt_b0 = '0; mt_b1 = '0; mt_e0 = 0; mt_e1 = 0;
        cmp_old = '1; cmp_new = '1; cmp_edge = 0;
        msip_old = 1'b0; msip_new = 1'b0; msip_edge = 0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset.data_ok", 64'(dresp.data_ok), 64'd0);
        chk("reset.data", dresp.data, 64'd0);
        chk("reset.sel", 64'(sel), 64'd0);
        chk_irq("reset");

        idle(10);
        xact("t1.mtime", A_MTIME, 8'h00, '0, got);
        chk("t1.mtime_is_10", got, 64'd10);

        xact("t2.cmp20", A_CMP, 8'hFF, 64'd20, got);
        idle(12);
        chk("t2.trint_high", 64'(trint), 64'd1);
        xact("t2.cmpmax", A_CMP, 8'hFF, '1, got);
        chk("t2.trint_low", 64'(trint), 64'd0);

        xact("t3.msip1", A_MSIP, 8'h01, 64'd1, got);
        chk("t3.swint_high", 64'(swint), 64'd1);
        xact("t3.msip0", A_MSIP, 8'h01, 64'd0, got);
        chk("t3.swint_low", 64'(swint), 64'd0);
        xact("t3.msipff", A_MSIP, 8'hFF, 64'hFF, got);
        xact("t3.msip_rd", A_MSIP, 8'h00, '0, got);
        chk("t3.msip_val", got, 64'd1);

        xact("t4.cmp_part", A_CMP, 8'h0F, 64'hAABB_CCDD_1122_3344, got);
        xact("t4.cmp_rd", A_CMP, 8'h00, '0, got);
        chk("t4.cmp_val", got, 64'hFFFF_FFFF_1122_3344);
        xact("t4.cmp_max", A_CMP, 8'hFF, '1, got);

        xact("t5.hole", BASE + 64'h100, 8'h00, '0, got);
        chk("t5.hole_val", got, 64'd0);
        xact("t5.hole_wr", BASE + 64'h108, 8'hFF, 64'h1234, got);
        xact("t5.top", BASE + 64'hFFFF, 8'h00, '0, got);
        miss("t5.far", 64'h8000_0000);
        miss("t5.above", BASE + 64'h1_0000);
        miss("t5.below", BASE - 64'd1);

        xact("t6.mt_wr", A_MTIME, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, got);
        xact("t6.mt_rd1", A_MTIME, 8'h00, '0, got);
`ifdef CLINT_MTIME_WRITE_EN
        chk("t6.mt_after1", got, 64'hFFFF_FFFF_FFFF_FFFF);
        xact("t6.mt_rd2", A_MTIME, 8'h00, '0, got);
        chk("t6.mt_wrapped", got, 64'd1);
`else
        chk("t6.mt_small", 64'(got < 64'd1000), 64'd1);
`endif

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            strb = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
            wd   = {$urandom, $urandom};
            case (kind)
                0: addr = A_MSIP;
                1: begin
                    addr = A_CMP;
                    if ($urandom_range(0, 1) == 1) wd = 64'($urandom_range(0, 800));
                end
                2: addr = A_MTIME;
                default: addr = BASE + {48'h0, 13'($urandom_range(1, 13'h07FF)), 3'b000};
            endcase
            addr = addr | 64'($urandom_range(0, 7));
            xact("rnd", addr, strb, wd, got);
            idle($urandom_range(0, 2));
        end

        xact("t7.msip1", A_MSIP, 8'h01, 64'd1, got);
        dreq.valid  = 1'b1;
        dreq.addr   = A_MTIME;
        dreq.strobe = 8'h00;
        @(posedge clk);
        #1;
        chk("t7.in_resp", 64'(dresp.data_ok), 64'd1);
        reset = 1'b1;
        #1;
        chk("t7.rst_ok", 64'(dresp.data_ok), 64'd0);
        chk("t7.rst_aok", 64'(dresp.addr_ok), 64'd0);
        chk("t7.rst_data", dresp.data, 64'd0);
        chk("t7.rst_trint", 64'(trint), 64'd0);
        chk("t7.rst_swint", 64'(swint), 64'd0);
        dreq.valid = 1'b0;
        @(negedge clk);
        chk("t7.held_ok", 64'(dresp.data_ok), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("t7.post_ok", 64'(dresp.data_ok), 64'd0);
        chk("t7.post_swint", 64'(swint), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
